// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int PORT_CORE = 0;
    localparam int PORT_DBG  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t own_state(input logic port);
        return port ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus: per-port request/ready plus the shared registered response.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import dmem_arb_pkg::*;

    logic [NUM_PORTS-1:0]             req_valid;
    logic [NUM_PORTS-1:0]             req_write;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0][2:0]        req_funct3;
    logic [NUM_PORTS-1:0]             req_ready;
    logic [NUM_PORTS-1:0]             rsp_valid;
    logic [DATA_W-1:0]                rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational round-robin pick with burst lock between the two requesters.
module rr_pick2
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  arb_state_t           state,
    input  logic [CNT_W-1:0]     burst_cnt,
    input  logic                 last_owner,
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic                 gnt_valid,
    output logic                 gnt_port
);

    logic owner;
    logic other;
    logic burst_full;

    assign owner      = (state == OWN1);
    assign other      = ~owner;
    assign burst_full = (burst_cnt == CNT_W'(MAX_BURST));

    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid[PORT_CORE] && req_valid[PORT_DBG]) begin
                    gnt_valid = 1'b1;
                    gnt_port  = ~last_owner;
                end else if (req_valid[PORT_CORE]) begin
                    gnt_valid = 1'b1;
                    gnt_port  = 1'b0;
                end else if (req_valid[PORT_DBG]) begin
                    gnt_valid = 1'b1;
                    gnt_port  = 1'b1;
                end
            end
            default: begin
                // Owner keeps the bus unless its burst is spent and the other port is waiting.
                if (req_valid[owner] && !(burst_full && req_valid[other])) begin
                    gnt_valid = 1'b1;
                    gnt_port  = owner;
                end else if (req_valid[other]) begin
                    gnt_valid = 1'b1;
                    gnt_port  = other;
                end
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory: zero-latency grant, registered read response.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     bus,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t           state;
    logic [CNT_W-1:0]     burst_cnt;
    logic                 last_owner;
    logic [NUM_PORTS-1:0] rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;

    logic gnt_valid;
    logic gnt_port;
    logic accept;

    rr_pick2 #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .state      (state),
        .burst_cnt  (burst_cnt),
        .last_owner (last_owner),
        .req_valid  (bus.req_valid),
        .gnt_valid  (gnt_valid),
        .gnt_port   (gnt_port)
    );

    // Reset is folded into accept so nothing is granted or written while rst is low.
    assign accept = gnt_valid & rst;

    always_comb begin
        bus.req_ready = '0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_funct3    = '0;
        if (gnt_valid) begin
            bus.req_ready[gnt_port] = accept;
            mem_write               = accept & bus.req_write[gnt_port];
            mem_addr                = bus.req_addr[gnt_port];
            mem_wdata               = bus.req_wdata[gnt_port];
            mem_funct3              = bus.req_funct3[gnt_port];
        end
    end

    // NOTE: all state and response registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_owner  <= 1'b1;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (accept) begin
                if (state == own_state(gnt_port)) begin
                    // A restarted burst (owner alone at the limit) begins counting again from one.
                    burst_cnt <= (burst_cnt == CNT_W'(MAX_BURST)) ? CNT_W'(1) : burst_cnt + 1'b1;
                end else begin
                    state      <= own_state(gnt_port);
                    burst_cnt  <= CNT_W'(1);
                    last_owner <= gnt_port;
                end
                if (!bus.req_write[gnt_port]) begin
                    rsp_valid_q[gnt_port] <= 1'b1;
                    rsp_rdata_q           <= mem_rdata;
                end
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one arbiter with MAX_BURST=4, a second with MAX_BURST=1.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    logic        mem_write0, mem_write1;
    logic [31:0] mem_addr0, mem_addr1;
    logic [31:0] mem_wdata0, mem_wdata1;
    logic [31:0] mem_rdata0, mem_rdata1;
    logic [2:0]  mem_funct3_0, mem_funct3_1;

    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];

    assign mem_rdata0 = mem0[mem_addr0[9:2]];
    assign mem_rdata1 = mem1[mem_addr1[9:2]];

    always @(posedge clk) begin
        if (mem_write0) mem0[mem_addr0[9:2]] <= mem_wdata0;
        if (mem_write1) mem1[mem_addr1[9:2]] <= mem_wdata1;
    end

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus0),
        .mem_write  (mem_write0),
        .mem_addr   (mem_addr0),
        .mem_wdata  (mem_wdata0),
        .mem_funct3 (mem_funct3_0),
        .mem_rdata  (mem_rdata0)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus1),
        .mem_write  (mem_write1),
        .mem_addr   (mem_addr1),
        .mem_wdata  (mem_wdata1),
        .mem_funct3 (mem_funct3_1),
        .mem_rdata  (mem_rdata1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_all();
        bus0.req_valid  = '0;
        bus0.req_write  = '0;
        bus0.req_addr   = '0;
        bus0.req_wdata  = '0;
        bus0.req_funct3 = '0;
        bus1.req_valid  = '0;
        bus1.req_write  = '0;
        bus1.req_addr   = '0;
        bus1.req_wdata  = '0;
        bus1.req_funct3 = '0;
    endtask

    task automatic drive0(input int p, input logic v, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        bus0.req_valid[p]  = v;
        bus0.req_write[p]  = w;
        bus0.req_addr[p]   = a;
        bus0.req_wdata[p]  = d;
        bus0.req_funct3[p] = f;
    endtask

    task automatic test_reset();
        drive0(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        drive0(1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (bus0.req_ready !== 2'b00) begin
                failures++;
                $display("FAIL reset_ready[%0d]: got %b want 00", i, bus0.req_ready);
            end
            checks++;
            if (mem_write0 !== 1'b0) begin
                failures++;
                $display("FAIL reset_mem_write[%0d]: got %b want 0", i, mem_write0);
            end
            tick();
            checks++;
            if (bus0.rsp_valid !== 2'b00) begin
                failures++;
                $display("FAIL reset_rsp_valid[%0d]: got %b want 00", i, bus0.rsp_valid);
            end
        end
        rst = 1'b1;
        settle();
        checks++;
        if (bus0.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL reset_release_tie: got %b want 01", bus0.req_ready);
        end
        tick();
        checks++;
        if (bus0.rsp_valid !== 2'b01 || bus0.rsp_rdata !== 32'h5000_0000) begin
            failures++;
            $display("FAIL reset_release_rsp: got %b/%h want 01/50000000", bus0.rsp_valid, bus0.rsp_rdata);
        end
        idle_all();
        tick();
    endtask

    task automatic test_single_load();
        drive0(1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
        settle();
        checks++;
        if (bus0.req_ready !== 2'b10 || mem_addr0 !== 32'h40 || mem_write0 !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: got ready=%b addr=%h we=%b want 10/00000040/0",
                     bus0.req_ready, mem_addr0, mem_write0);
        end
        tick();
        idle_all();
        checks++;
        if (bus0.rsp_valid !== 2'b10 || bus0.rsp_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_rsp: got %b/%h want 10/deadbeef", bus0.rsp_valid, bus0.rsp_rdata);
        end
        tick();
        checks++;
        if (bus0.rsp_valid !== 2'b00 || bus0.rsp_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_hold: got %b/%h want 00/deadbeef", bus0.rsp_valid, bus0.rsp_rdata);
        end
    endtask

    task automatic test_burst_lock();
        drive0(1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
        for (int i = 1; i <= 4; i++) begin
            drive0(0, 1'b1, 1'b1, 32'h200 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 3'b010);
            settle();
            checks++;
            if (bus0.req_ready !== 2'b01 || mem_write0 !== 1'b1 ||
                mem_wdata0 !== 32'hC0DE_0000 + 32'(i)) begin
                failures++;
                $display("FAIL burst_owner[%0d]: got ready=%b we=%b wdata=%h want 01/1/%h",
                         i, bus0.req_ready, mem_write0, mem_wdata0, 32'hC0DE_0000 + 32'(i));
            end
            tick();
        end
        settle();
        checks++;
        if (bus0.req_ready !== 2'b10 || mem_write0 !== 1'b0) begin
            failures++;
            $display("FAIL burst_handover: got ready=%b we=%b want 10/0", bus0.req_ready, mem_write0);
        end
        tick();
        checks++;
        if (bus0.rsp_valid !== 2'b10 || bus0.rsp_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL burst_dbg_rsp: got %b/%h want 10/deadbeef", bus0.rsp_valid, bus0.rsp_rdata);
        end
        bus0.req_valid[1] = 1'b0;
        settle();
        checks++;
        if (bus0.req_ready !== 2'b01 || mem_write0 !== 1'b1) begin
            failures++;
            $display("FAIL burst_return: got ready=%b we=%b want 01/1", bus0.req_ready, mem_write0);
        end
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_alternation();
        int          cnt [2];
        int          p;
        logic [1:0]  exp_onehot;
        logic [31:0] exp_data;
        cnt[0] = 0;
        cnt[1] = 0;
        bus1.req_valid  = 2'b11;
        bus1.req_write  = 2'b00;
        bus1.req_funct3 = {3'b010, 3'b010};
        for (int i = 0; i < 6; i++) begin
            p          = i % 2;
            exp_onehot = (p == 1) ? 2'b10 : 2'b01;
            exp_data   = 32'hA000_0000 + ((p == 1) ? 32'(32 + cnt[1]) : 32'(cnt[0]));
            bus1.req_addr[0] = 32'(cnt[0] * 4);
            bus1.req_addr[1] = 32'h80 + 32'(cnt[1] * 4);
            settle();
            checks++;
            if (bus1.req_ready !== exp_onehot) begin
                failures++;
                $display("FAIL alt_grant[%0d]: got %b want %b", i, bus1.req_ready, exp_onehot);
            end
            tick();
            checks++;
            if (bus1.rsp_valid !== exp_onehot || bus1.rsp_rdata !== exp_data) begin
                failures++;
                $display("FAIL alt_rsp[%0d]: got %b/%h want %b/%h",
                         i, bus1.rsp_valid, bus1.rsp_rdata, exp_onehot, exp_data);
            end
            cnt[p]++;
            if (cnt[p] == 3) bus1.req_valid[p] = 1'b0;
        end
        idle_all();
        tick();
        checks++;
        if (bus1.rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL alt_quiet: got %b want 00", bus1.rsp_valid);
        end
    endtask

    task automatic test_store_load();
        drive0(0, 1'b1, 1'b1, 32'h100, 32'h1234_5678, 3'b010);
        settle();
        checks++;
        if (bus0.req_ready !== 2'b01 || mem_write0 !== 1'b1 || mem_addr0 !== 32'h100 ||
            mem_wdata0 !== 32'h1234_5678 || mem_funct3_0 !== 3'b010) begin
            failures++;
            $display("FAIL store_bus: got ready=%b we=%b addr=%h wdata=%h f3=%b want 01/1/00000100/12345678/010",
                     bus0.req_ready, mem_write0, mem_addr0, mem_wdata0, mem_funct3_0);
        end
        tick();
        idle_all();
        drive0(1, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
        settle();
        checks++;
        if (bus0.req_ready !== 2'b10 || mem_write0 !== 1'b0) begin
            failures++;
            $display("FAIL load_after_store_grant: got ready=%b we=%b want 10/0", bus0.req_ready, mem_write0);
        end
        tick();
        idle_all();
        checks++;
        if (bus0.rsp_valid !== 2'b10 || bus0.rsp_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL load_after_store_rsp: got %b/%h want 10/12345678", bus0.rsp_valid, bus0.rsp_rdata);
        end
        settle();
        checks++;
        if (mem_write0 !== 1'b0 || mem_addr0 !== 32'h0) begin
            failures++;
            $display("FAIL idle_bus: got we=%b addr=%h want 0/00000000", mem_write0, mem_addr0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive0(0, 1'b1, 1'b1, 32'h300, 32'hFACE_0001, 3'b010);
        settle();
        checks++;
        if (bus0.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL mid_pre_grant: got %b want 01", bus0.req_ready);
        end
        tick();
        idle_all();
        drive0(1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
        rst = 1'b0;
        settle();
        checks++;
        if (bus0.req_ready !== 2'b00 || mem_write0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ready: got ready=%b we=%b want 00/0", bus0.req_ready, mem_write0);
        end
        tick();
        checks++;
        if (bus0.rsp_valid !== 2'b00 || bus0.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_rsp: got %b/%h want 00/00000000", bus0.rsp_valid, bus0.rsp_rdata);
        end
        rst = 1'b1;
        drive0(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        settle();
        checks++;
        if (bus0.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL mid_after_tie: got %b want 01", bus0.req_ready);
        end
        tick();
        idle_all();
        checks++;
        if (bus0.rsp_valid !== 2'b01 || bus0.rsp_rdata !== 32'h5000_0000) begin
            failures++;
            $display("FAIL mid_after_rsp: got %b/%h want 01/50000000", bus0.rsp_valid, bus0.rsp_rdata);
        end
        tick();
        checks++;
        if (bus0.rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL mid_after_quiet: got %b want 00", bus0.rsp_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h5000_0000 + 32'(i);
            mem1[i] = 32'hA000_0000 + 32'(i);
        end
        mem0[16] = 32'hDEAD_BEEF;
        idle_all();
        rst = 1'b0;

        test_reset();
        test_single_load();
        test_burst_lock();
        test_alternation();
        test_store_load();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Sits between the requesters and the data memory. The memory has a combinational read and a write on the clock edge.
- Arbitration is round-robin with a bounded burst lock. Grant is zero-latency, and read data is returned on a registered response one cycle after acceptance.

Parameters:
- ADDR_W, 32, address width of requests and of the memory address output.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive accepts by one owner while the other port waits; must be >= 1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_write  in  2  per-port 1 = store, 0 = load.
- req_addr  in  2xADDR_W  per-port byte address.
- req_wdata  in  2xDATA_W  per-port store data.
- req_funct3  in  2x3  per-port access size/sign code, passed through to memory.
- req_ready  out  2  per-port accept; a transfer occurs when valid & ready.
- rsp_valid  out  2  per-port read-data valid, one cycle after an accepted load.
- rsp_rdata  out  DATA_W  registered read data, shared by both ports and qualified by rsp_valid.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory store data.
- mem_funct3  out  3  memory funct3.
- mem_rdata  in  DATA_W  combinational memory read data.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = IDLE, burst_cnt = 0, last_owner = 1 (so port 0 wins the first tie).
  - rsp_valid = 0, rsp_rdata = 0.
  - While rst == 0: req_ready = 0 and mem_write = 0.
  - A load accepted in the cycle reset asserts is dropped (no response).
- States: IDLE, OWN0, OWN1. Each cycle a combinational pick g (port 0, port 1 or none) is made from the state:
  - IDLE: if only one port is valid, g = that port. If both are valid, g = the port that is not last_owner.
  - OWNx, x valid and burst_cnt < MAX_BURST: g = x.
  - OWNx, x valid, burst_cnt == MAX_BURST, other port valid: g = other.
  - OWNx, x valid, burst_cnt == MAX_BURST, other port idle: g = x and burst_cnt restarts.
  - OWNx, x not valid, other port valid: g = other.
  - OWNx, neither valid: g = none.
- req_ready[g] = 1 and the other ready = 0. At most one port is ready per cycle, and never a port whose valid is 0.
- Memory outputs follow port g. mem_write = accept & req_write[g]. When g = none, mem_addr/mem_wdata/mem_funct3 = 0.
- Next state on each edge:
  - Accept by g == current owner: stay in OWNg, burst_cnt += 1 (burst_cnt = 1 if restarting).
  - Accept by a different port (or from IDLE): go to OWNg, burst_cnt = 1, last_owner = g.
  - No accept: go to IDLE, burst_cnt = 0.
- burst_cnt saturates at MAX_BURST. With MAX_BURST = 1 the ports strictly alternate under contention.
- Response:
  - An accepted load sets rsp_valid[g] = 1 and rsp_rdata = mem_rdata on the next edge.
  - Store accepts produce no response.
  - rsp_valid lasts exactly one cycle per accepted load. Back-to-back loads give back-to-back responses with no bubble.
  - rsp_rdata holds its value when rsp_valid == 0.
- Requesters must hold addr/wdata/write/funct3 stable while valid && !ready. The arbiter does not check this.
- No alignment checking; addresses pass through unchanged.
- Starvation bound: a valid port waits at most MAX_BURST cycles.

Decomposition:
- Package dmem_arb_pkg holds:
  - enum arb_state_t {IDLE, OWN0, OWN1};
  - constants PORT_CORE = 0 and PORT_DBG = 1;
  - localparam NUM_PORTS = 2.
- One sub-module, rr_pick2: purely combinational pick from (state, burst_cnt, last_owner, req_valid) to g.
- The top-level dmem_arbiter holds the state/counter/response registers and the muxing.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with both ports valid -> req_ready = 00, mem_write = 0, rsp_valid = 00; first cycle after release with both valid -> req_ready = 01.
- Single-port load:
  - Stimulus: port 1 load of addr 0x40, with memory word 0xDEADBEEF at that address.
  - Required: ready[1] = 1 in the same cycle; next cycle rsp_valid = 10 and rsp_rdata = 0xDEADBEEF.
- Burst lock:
  - Stimulus: MAX_BURST = 4; port 0 stores continuously, port 1 raises valid in port 0's first accept cycle.
  - Required: port 0 gets 4 accepts, then port 1 is granted in cycle 5 and port 0 again in cycle 6 if port 1 drops.
- Alternation: MAX_BURST = 1 with both ports issuing 6 loads -> grants alternate 0,1,0,1,0,1; each rsp_valid pulse appears on the matching bit one cycle later.
- Store then load same address:
  - Stimulus: port 0 stores 0x12345678 to 0x100 (funct3 = 010), then port 1 loads 0x100.
  - Required: mem_write = 1 for exactly one cycle; port 1 rsp_rdata = 0x12345678.
- Reset mid-operation: assert rst = 0 in the cycle a port 1 load is accepted -> no rsp_valid pulse afterwards; state returns to IDLE and the next tie goes to port 0.
